// File: rtl/fu_cdb_arbiter.sv
// rtl/fu_cdb_arbiter.sv - per-FU result queues with round-robin serialisation onto the CDB

package fu_cdb_pkg;

  // One CDB broadcast record: destination register and result value.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } cdb_t;

endpackage

module fu_cdb_arbiter
  import fu_cdb_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int QDEPTH = 2,
  parameter int IDX_W  = $clog2(NUM_FU)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NUM_FU-1:0]     fu_complete_valid,
  input  cdb_t [NUM_FU-1:0]     fu_complete_data,
  output logic [NUM_FU-1:0]     fu_stall,
  output logic                  cdb_valid,
  output cdb_t                  cdb_data,
  output logic [IDX_W-1:0]      cdb_src,
  output logic                  overflow_err
);

  // Pointer width wraps naturally because QDEPTH is a power of two;
  // the count needs one extra state to represent "full".
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [CW-1:0]    COUNT_FULL  = CW'(QDEPTH);
  localparam logic [CW-1:0]    COUNT_STALL = CW'(QDEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_FU     = IDX_W'(NUM_FU - 1);

  // ---------------------------------------------------------------------------
  // Queue state
  // ---------------------------------------------------------------------------
  cdb_t          mem_q   [NUM_FU][QDEPTH];
  logic [PW-1:0] wptr_q  [NUM_FU];
  logic [PW-1:0] wptr_d  [NUM_FU];
  logic [PW-1:0] rptr_q  [NUM_FU];
  logic [PW-1:0] rptr_d  [NUM_FU];
  logic [CW-1:0] count_q [NUM_FU];
  logic [CW-1:0] count_d [NUM_FU];

  // ---------------------------------------------------------------------------
  // Arbiter and CDB output state
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;
  logic             cdb_valid_q;
  logic             cdb_valid_d;
  cdb_t             cdb_data_q;
  cdb_t             cdb_data_d;
  logic [IDX_W-1:0] cdb_src_q;
  logic [IDX_W-1:0] cdb_src_d;
  logic             overflow_q;
  logic             overflow_d;

  // ---------------------------------------------------------------------------
  // Per-queue status and handshakes
  // ---------------------------------------------------------------------------
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              drop;

  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  cdb_t              head_data;

  // Queue status flags; stall is raised one entry early so a same-cycle issue
  // to a single-cycle FU still has a slot when its result lands.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      full[i]     = (count_q[i] == COUNT_FULL);
      req[i]      = (count_q[i] != '0);
      fu_stall[i] = (count_q[i] >= COUNT_STALL);
    end
  end

  // Round-robin search starting at rr; iterating downward lets the nearest
  // requester (smallest offset from rr) win the final assignment.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_FU) begin
        idx = idx - NUM_FU;
      end
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  // Head of the granted queue; only meaningful when grant_valid is set.
  always_comb begin
    head_data = mem_q[grant_idx][rptr_q[grant_idx]];
  end

  // Push/pop qualification. A flush discards everything arriving this cycle,
  // and a completion into a full queue is dropped and flagged.
  always_comb begin
    drop = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i] = fu_complete_valid[i] & ~full[i] & ~flush;
      pop[i]  = grant_valid & (grant_idx == IDX_W'(i)) & ~flush;
      if (fu_complete_valid[i] && full[i] && !flush) begin
        drop = 1'b1;
      end
    end
  end

  // Next-state for pointers and occupancy of every queue.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
      count_d[i] = count_q[i];
      if (flush) begin
        wptr_d[i]  = '0;
        rptr_d[i]  = '0;
        count_d[i] = '0;
      end else begin
        if (push[i]) begin
          wptr_d[i] = wptr_q[i] + PW'(1);
        end
        if (pop[i]) begin
          rptr_d[i] = rptr_q[i] + PW'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count_d[i] = count_q[i] + CW'(1);
          2'b01:   count_d[i] = count_q[i] - CW'(1);
          default: count_d[i] = count_q[i];
        endcase
      end
    end
  end

  // Next-state for the CDB register, round-robin pointer and sticky error.
  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_data_d  = '0;
    cdb_src_d   = cdb_src_q;
    rr_d        = rr_q;
    overflow_d  = overflow_q | drop;
    if (!flush && grant_valid) begin
      cdb_valid_d = 1'b1;
      cdb_data_d  = head_data;
      cdb_src_d   = grant_idx;
      rr_d        = (grant_idx == LAST_FU) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Register queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  // Queue storage: contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= fu_complete_data[i];
      end
    end
  end

  // Register the CDB broadcast, arbitration pointer and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rr_q        <= '0;
      overflow_q  <= 1'b0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      rr_q        <= rr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_src      = cdb_src_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// tb/tb_fu_cdb_arbiter.sv - self-checking bench for fu_cdb_arbiter

module tb_fu_cdb_arbiter;
  import fu_cdb_pkg::*;

  localparam int NUM_FU = 4;
  localparam int QDEPTH = 2;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [3:0]        fu_complete_valid;
  cdb_t [3:0]        fu_complete_data;
  logic [3:0]        fu_stall;
  logic              cdb_valid;
  cdb_t              cdb_data;
  logic [1:0]        cdb_src;
  logic              overflow_err;

  fu_cdb_arbiter #(.NUM_FU(NUM_FU), .QDEPTH(QDEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .fu_complete_valid (fu_complete_valid),
    .fu_complete_data  (fu_complete_data),
    .fu_stall          (fu_stall),
    .cdb_valid         (cdb_valid),
    .cdb_data          (cdb_data),
    .cdb_src           (cdb_src),
    .overflow_err      (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic [3:0] v;
    cdb_t [3:0] d;
    logic       ev;
    logic [1:0] esrc;
    cdb_t       ed;
    logic [3:0] estall;
    logic       eovf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: one plain queue per FU plus the broadcast registers.
  cdb_t m_q[4][$];
  int   m_rr;
  bit   m_v;
  cdb_t m_d;
  int   m_src;
  bit   m_ovf;

  function automatic cdb_t c(input logic [4:0] rd, input logic [31:0] data);
    cdb_t r;
    r.rd   = rd;
    r.data = data;
    return r;
  endfunction

  function automatic vec_t mk(input bit r, input bit f, input logic [3:0] v,
                              input cdb_t d0, input cdb_t d1, input cdb_t d2, input cdb_t d3,
                              input bit ev, input logic [1:0] es, input cdb_t ed,
                              input logic [3:0] st, input bit eo);
    vec_t x;
    x.rst    = r;
    x.flush  = f;
    x.v      = v;
    x.d[0]   = d0;
    x.d[1]   = d1;
    x.d[2]   = d2;
    x.d[3]   = d3;
    x.ev     = ev;
    x.esrc   = es;
    x.ed     = ed;
    x.estall = st;
    x.eovf   = eo;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit r, input bit f, input logic [3:0] v, input cdb_t [3:0] d);
    bit was_full[4];
    int g;
    if (r) begin
      for (int i = 0; i < 4; i++) m_q[i].delete();
      m_rr = 0; m_v = 0; m_d = '0; m_src = 0; m_ovf = 0;
    end else if (f) begin
      for (int i = 0; i < 4; i++) m_q[i].delete();
      m_v = 0; m_d = '0;
    end else begin
      for (int i = 0; i < 4; i++) was_full[i] = (m_q[i].size() == QDEPTH);
      g = -1;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_rr + k) % 4;
        if (g < 0 && m_q[j].size() > 0) g = j;
      end
      if (g >= 0) begin
        m_d   = m_q[g].pop_front();
        m_v   = 1;
        m_src = g;
        m_rr  = (g + 1) % 4;
      end else begin
        m_v = 0;
        m_d = '0;
      end
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          if (was_full[i]) m_ovf = 1;
          else m_q[i].push_back(d[i]);
        end
      end
    end
  endtask

  function automatic logic [3:0] model_stall();
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = (m_q[i].size() >= QDEPTH - 1);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cdb_t z;
    cdb_t seen0[$];
    bit   a3_seen;
    cdb_t a[4];
    z = '0;

    rst = 1'b1;
    flush = 1'b0;
    fu_complete_valid = '0;
    fu_complete_data  = '0;

    // ---------------- table-driven directed vectors ----------------
    vecs.push_back(mk(1,0,4'b0000, z,z,z,z, 0,2'd0,z,4'b0000,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 0,2'd0,z,4'b0000,0));
    vecs.push_back(mk(0,0,4'b0010, z,c(5,32'hAA),z,z, 0,2'd0,z,4'b0010,0));
    vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 1,2'd1,c(5,32'hAA),4'b0000,0));
    vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 0,2'd1,z,4'b0000,0));
    vecs.push_back(mk(1,0,4'b0000, z,z,z,z, 0,2'd0,z,4'b0000,0));
    for (int b = 0; b < 2; b++) begin
      vecs.push_back(mk(0,0,4'b1111, c(0,1),c(1,2),c(2,3),c(3,4), 0,(b==0)?2'd0:2'd3,z,4'b1111,0));
      vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 1,2'd0,c(0,1),4'b1110,0));
      vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 1,2'd1,c(1,2),4'b1100,0));
      vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 1,2'd2,c(2,3),4'b1000,0));
      vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 1,2'd3,c(3,4),4'b0000,0));
      vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 0,2'd3,z,4'b0000,0));
    end
    vecs.push_back(mk(0,0,4'b0010, z,c(7,32'h10),z,z, 0,2'd3,z,4'b0010,0));
    vecs.push_back(mk(0,0,4'b1001, c(8,32'h20),z,z,c(9,32'h30), 1,2'd1,c(7,32'h10),4'b1001,0));
    vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 1,2'd3,c(9,32'h30),4'b0001,0));
    vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 1,2'd0,c(8,32'h20),4'b0000,0));
    vecs.push_back(mk(0,0,4'b0011, c(10,32'h40),c(11,32'h50),z,z, 0,2'd0,z,4'b0011,0));
    vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 1,2'd1,c(11,32'h50),4'b0001,0));
    vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 1,2'd0,c(10,32'h40),4'b0000,0));
    vecs.push_back(mk(0,0,4'b0000, z,z,z,z, 0,2'd0,z,4'b0000,0));

    foreach (vecs[k]) begin
      rst               = vecs[k].rst;
      flush             = vecs[k].flush;
      fu_complete_valid = vecs[k].v;
      fu_complete_data  = vecs[k].d;
      tick();
      chk($sformatf("vec%0d cdb_valid", k), 64'(cdb_valid), 64'(vecs[k].ev));
      chk($sformatf("vec%0d cdb_src", k), 64'(cdb_src), 64'(vecs[k].esrc));
      chk($sformatf("vec%0d cdb_data", k), 64'(cdb_data), 64'(vecs[k].ed));
      chk($sformatf("vec%0d fu_stall", k), 64'(fu_stall), 64'(vecs[k].estall));
      chk($sformatf("vec%0d overflow_err", k), 64'(overflow_err), 64'(vecs[k].eovf));
    end

    // ---------------- stall / overflow sequence ----------------
    rst = 1'b1; fu_complete_valid = '0; fu_complete_data = '0;
    tick();
    rst = 1'b0;
    a[0] = c(1, 32'hA0); a[1] = c(1, 32'hA1); a[2] = c(1, 32'hA2); a[3] = c(1, 32'hA3);
    a3_seen = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      fu_complete_valid = (cyc < 2) ? 4'b1111 : 4'b0001;
      fu_complete_data[0] = a[cyc];
      fu_complete_data[1] = c(2, 32'hB1 + 32'(cyc));
      fu_complete_data[2] = c(3, 32'hB2 + 32'(cyc));
      fu_complete_data[3] = c(4, 32'hB3 + 32'(cyc));
      tick();
      if (cdb_valid && cdb_src == 2'd0) seen0.push_back(cdb_data);
      if (cdb_valid && cdb_data == a[3]) a3_seen = 1;
      chk($sformatf("ovf_seq cyc%0d fu_stall[0]", cyc), 64'(fu_stall[0]), 64'd1);
      chk($sformatf("ovf_seq cyc%0d overflow_err", cyc), 64'(overflow_err), (cyc == 3) ? 64'd1 : 64'd0);
    end
    fu_complete_valid = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (cdb_valid && cdb_src == 2'd0) seen0.push_back(cdb_data);
      if (cdb_valid && cdb_data == a[3]) a3_seen = 1;
    end
    chk("ovf_seq dropped record absent", 64'(a3_seen), 64'd0);
    chk("ovf_seq fu0 count", 64'(seen0.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < seen0.size()) chk($sformatf("ovf_seq fu0 order %0d", i), 64'(seen0[i]), 64'(a[i]));
    end
    chk("ovf_seq sticky", 64'(overflow_err), 64'd1);

    // ---------------- flush sequence ----------------
    fu_complete_valid = 4'b0111;
    fu_complete_data  = {c(0,32'h0), c(3,32'hF2), c(2,32'hF1), c(1,32'hF0)};
    tick();
    chk("flush load stall", 64'(fu_stall), 64'b0111);
    flush = 1'b1;
    fu_complete_valid = 4'b0100;
    tick();
    flush = 1'b0;
    fu_complete_valid = '0;
    chk("flush cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush cdb_data", 64'(cdb_data), 64'd0);
    chk("flush fu_stall", 64'(fu_stall), 64'd0);
    chk("flush overflow_err", 64'(overflow_err), 64'd1);
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      chk($sformatf("post_flush cyc%0d cdb_valid", cyc), 64'(cdb_valid), 64'd0);
    end
    // rr was 1 before the flush and must still be 1: FU1 beats FU0.
    fu_complete_valid = 4'b0011;
    fu_complete_data  = {c(0,0), c(0,0), c(6,32'hE1), c(5,32'hE0)};
    tick();
    fu_complete_valid = '0;
    tick();
    chk("flush rr hold src", 64'(cdb_src), 64'd1);
    chk("flush rr hold data", 64'(cdb_data), 64'(c(6,32'hE1)));

    // ---------------- randomized run against the model ----------------
    rst = 1'b1;
    model_step(1, 0, '0, '0);
    tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cdb_t [3:0] d;
      logic [3:0] v;
      bit r, f;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < 4; i++) begin
        v[i]      = ($urandom_range(0, 99) < 45);
        d[i].rd   = 5'($urandom);
        d[i].data = $urandom;
      end
      rst = r; flush = f; fu_complete_valid = v; fu_complete_data = d;
      model_step(r, f, v, d);
      tick();
      chk($sformatf("rand%0d cdb_valid", cyc), 64'(cdb_valid), 64'(m_v));
      chk($sformatf("rand%0d cdb_data", cyc), 64'(cdb_data), 64'(m_d));
      chk($sformatf("rand%0d cdb_src", cyc), 64'(cdb_src), 64'(m_src));
      chk($sformatf("rand%0d fu_stall", cyc), 64'(fu_stall), 64'(model_stall()));
      chk($sformatf("rand%0d overflow_err", cyc), 64'(overflow_err), 64'(m_ovf));
    end
    rst = 1'b0; flush = 1'b0; fu_complete_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
